// File: rtl/gtfwizard_0_delay_powergood_mc.sv
// Multi-channel GTPOWERGOOD qualifier: holds the TX PMA safe until each
// channel's power-good has been stable for DELAY_CYCLES, then hands control back.
module gtfwizard_0_delay_powergood_mc #(
    parameter int C_USER_GTPOWERGOOD_DELAY_EN = 1,
    parameter int NUM_CH                      = 4,
    parameter int DELAY_CYCLES                = 256,
    parameter int SYNC_STAGES                 = 3,
    parameter int DROP_CNT_W                  = 8
) (
    input  logic                         GT_TXOUTCLKPCS,
    input  logic                         RESET,
    input  logic [NUM_CH-1:0]            GT_GTPOWERGOOD,
    input  logic [NUM_CH-1:0]            USER_GTTXRESET,
    input  logic [NUM_CH-1:0]            USER_TXPMARESET,
    input  logic [NUM_CH-1:0]            USER_TXPISOPD,
    input  logic [NUM_CH-1:0]            USER_PG_REARM,
    input  logic                         USER_DROP_CNT_CLR,
    output logic [NUM_CH-1:0]            USER_GTPOWERGOOD,
    output logic                         USER_ALL_POWERGOOD,
    output logic [NUM_CH-1:0]            GT_GTTXRESET,
    output logic [NUM_CH-1:0]            GT_TXPMARESET,
    output logic [NUM_CH-1:0]            GT_TXPISOPD,
    output logic [NUM_CH*DROP_CNT_W-1:0] USER_PG_DROP_CNT
);

    localparam int CW = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    if (C_USER_GTPOWERGOOD_DELAY_EN == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{GT_TXOUTCLKPCS, RESET, USER_PG_REARM,
                                 USER_DROP_CNT_CLR};

        assign USER_GTPOWERGOOD   = GT_GTPOWERGOOD;
        assign USER_ALL_POWERGOOD = &GT_GTPOWERGOOD;
        assign GT_GTTXRESET       = USER_GTTXRESET;
        assign GT_TXPMARESET      = USER_TXPMARESET;
        assign GT_TXPISOPD        = USER_TXPISOPD;
        assign USER_PG_DROP_CNT   = '0;
    end else begin : g_delay
        logic [NUM_CH-1:0] done_vec;
        logic              all_r;

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
            logic [SYNC_STAGES-1:0] sync;
            logic                   pg;
            state_t                 state;
            state_t                 state_nx;
            logic [CW-1:0]          cnt;
            logic [CW-1:0]          cnt_nx;
            logic                   drop;
            logic                   done_r;
            logic [DROP_CNT_W-1:0]  drop_cnt;

            always_ff @(posedge GT_TXOUTCLKPCS) begin
                if (RESET) begin
                    sync <= '0;
                end else begin
                    sync <= {sync[SYNC_STAGES-2:0], GT_GTPOWERGOOD[c]};
                end
            end

            assign pg = sync[SYNC_STAGES-1];

            // Re-arm beats the power-good checks and never counts as a drop.
            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                drop     = 1'b0;
                unique case (state)
                    S_IDLE: begin
                        if (pg) begin
                            state_nx = S_WAIT;
                            cnt_nx   = '0;
                        end
                    end
                    S_WAIT: begin
                        if (USER_PG_REARM[c] || !pg) begin
                            state_nx = S_IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state_nx = S_DONE;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        if (USER_PG_REARM[c]) begin
                            state_nx = S_IDLE;
                        end else if (!pg) begin
                            state_nx = S_IDLE;
                            drop     = 1'b1;
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end

            always_ff @(posedge GT_TXOUTCLKPCS) begin
                if (RESET) begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    done_r <= 1'b0;
                end else begin
                    state  <= state_nx;
                    cnt    <= cnt_nx;
                    done_r <= (state == S_DONE);
                end
            end

            always_ff @(posedge GT_TXOUTCLKPCS) begin
                if (RESET || USER_DROP_CNT_CLR) begin
                    drop_cnt <= '0;
                end else if (drop && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end

            assign done_vec[c]         = done_r;
            assign USER_GTPOWERGOOD[c] = done_r;
            assign GT_TXPISOPD[c]      = done_r ? USER_TXPISOPD[c]   : 1'b1;
            assign GT_GTTXRESET[c]     = done_r ? USER_GTTXRESET[c]  : 1'b1;
            assign GT_TXPMARESET[c]    = done_r ? USER_TXPMARESET[c] : 1'b0;
            assign USER_PG_DROP_CNT[c*DROP_CNT_W +: DROP_CNT_W] = drop_cnt;
        end

        always_ff @(posedge GT_TXOUTCLKPCS) begin
            if (RESET) begin
                all_r <= 1'b0;
            end else begin
                all_r <= &done_vec;
            end
        end

        assign USER_ALL_POWERGOOD = all_r;
    end

endmodule
